// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port, length and payload are sent MSB-first, then a forced idle gap.
// Define PARITY_EN to append an even-parity bit over the port, length and payload bits.
module serial_frame_tx #(
    parameter int unsigned PORT_W   = 2,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [PORT_W-1:0] tx_port,
    input  logic [LEN_W-1:0]  tx_len,
    input  logic [DATA_W-1:0] tx_data,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned MAX_PL  = (PORT_W > LEN_W) ? PORT_W : LEN_W;
    localparam int unsigned MAX_PLD = (MAX_PL > (2 ** LEN_W)) ? MAX_PL : (2 ** LEN_W);
    localparam int unsigned MAX_ALL = (MAX_PLD > IDLE_GAP) ? MAX_PLD : IDLE_GAP;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        PORT  = 3'd2,
        LEN   = 3'd3,
        DATA  = 3'd4,
`ifdef PARITY_EN
        PAR   = 3'd6,
`endif
        GAP   = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [PORT_W-1:0] port_q, port_n, port_sh;
    logic [LEN_W-1:0]  len_q, len_n, len_sh;
    logic [DATA_W-1:0] data_q, data_n, data_sh;
    logic              ser_n, ready_n, busy_n, done_n;
`ifdef PARITY_EN
    logic              par_q, par_n;
`endif

    // State, captured request and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            port_q     <= '0;
            len_q      <= '0;
            data_q     <= '0;
            ser_out    <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            port_q     <= port_n;
            len_q      <= len_n;
            data_q     <= data_n;
            ser_out    <= ser_n;
            tx_ready   <= ready_n;
            busy       <= busy_n;
            frame_done <= done_n;
`ifdef PARITY_EN
            par_q      <= par_n;
`endif
        end
    end

    // Next state; outputs are derived from the state being entered so they line up with it
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        port_n  = port_q;
        len_n   = len_q;
        data_n  = data_q;
        ser_n   = 1'b1;
        done_n  = 1'b0;
`ifdef PARITY_EN
        par_n   = par_q;
`endif

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n = START;
                    port_n  = tx_port;
                    len_n   = tx_len;
                    data_n  = tx_data;
`ifdef PARITY_EN
                    par_n   = 1'b0;
`endif
                end
            end
            START: begin
                state_n = PORT;
                cnt_n   = CNT_W'(PORT_W - 1);
            end
            PORT: begin
                if (cnt == '0) begin
                    state_n = LEN;
                    cnt_n   = CNT_W'(LEN_W - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            LEN: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (len_q != '0) begin
                    state_n = DATA;
                    cnt_n   = CNT_W'(len_q) - CNT_W'(1);
                end else begin
`ifdef PARITY_EN
                    state_n = PAR;
`else
                    state_n = GAP;
`endif
                end
            end
            DATA: begin
                if (cnt == '0) begin
`ifdef PARITY_EN
                    state_n = PAR;
`else
                    state_n = GAP;
`endif
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
`ifdef PARITY_EN
            PAR: begin
                state_n = GAP;
            end
`endif
            GAP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Gap counter reload and the end-of-frame pulse happen only on GAP entry
        if (state_n == GAP && state != GAP) begin
            cnt_n  = CNT_W'(IDLE_GAP - 1);
            done_n = 1'b1;
        end

        port_sh = port_q >> cnt_n;
        len_sh  = len_q >> cnt_n;
        data_sh = data_q >> cnt_n;

        case (state_n)
            START:   ser_n = 1'b0;
            PORT:    ser_n = port_sh[0];
            LEN:     ser_n = len_sh[0];
            DATA:    ser_n = data_sh[0];
`ifdef PARITY_EN
            PAR:     ser_n = par_q;
`endif
            default: ser_n = 1'b1;
        endcase

`ifdef PARITY_EN
        if (state_n == PORT || state_n == LEN || state_n == DATA) begin
            par_n = par_n ^ ser_n;
        end
`endif

        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx; expected frames are hand-encoded bit strings, MSB = first bit sent.
// Honours PARITY_EN to select the matching expected frames.
module tb_serial_frame_tx;

    logic        clk;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  tx_port;
    logic [3:0]  tx_len;
    logic [15:0] tx_data;
    logic        ser_out;
    logic        busy;
    logic        frame_done;

    int nvec = 0;
    int nerr = 0;

    serial_frame_tx #(
        .PORT_W  (2),
        .LEN_W   (4),
        .DATA_W  (16),
        .IDLE_GAP(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_port   (tx_port),
        .tx_len    (tx_len),
        .tx_data   (tx_data),
        .ser_out   (ser_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept happens at the next rising edge; bits are sampled on each following falling edge.
    task automatic run_frame(input string tag, input logic [31:0] exp, input int f, input bit drop,
                             input logic [1:0] np, input logic [3:0] nl, input logic [15:0] nd);
        @(posedge clk);
        for (int k = 0; k < f + 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tx_port = np;
                tx_len  = nl;
                tx_data = nd;
                if (drop) tx_valid = 1'b0;
                chk($sformatf("%s.busy0", tag), 32'(busy), 32'd1);
                chk($sformatf("%s.ready0", tag), 32'(tx_ready), 32'd0);
            end
            if (k < f) begin
                chk($sformatf("%s.bit%0d", tag, k), 32'(ser_out), 32'(exp[f-1-k]));
                if (k == f - 1) chk($sformatf("%s.done_early", tag), 32'(frame_done), 32'd0);
            end else if (k == f) begin
                chk($sformatf("%s.gap_line", tag), 32'(ser_out), 32'd1);
                chk($sformatf("%s.done", tag), 32'(frame_done), 32'd1);
                chk($sformatf("%s.ready_gap", tag), 32'(tx_ready), 32'd0);
            end else begin
                chk($sformatf("%s.done_clr", tag), 32'(frame_done), 32'd0);
                chk($sformatf("%s.ready", tag), 32'(tx_ready), 32'd1);
                chk($sformatf("%s.busy_clr", tag), 32'(busy), 32'd0);
                chk($sformatf("%s.idle_line", tag), 32'(ser_out), 32'd1);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_port  = '0;
        tx_len   = '0;
        tx_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst.ser", 32'(ser_out), 32'd1);
        chk("rst.ready", 32'(tx_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset asserted mid-payload aborts the frame at once
        tx_valid = 1'b1; tx_port = 2'b01; tx_len = 4'd5; tx_data = 16'h0015;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        chk("abort.pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort.ser", 32'(ser_out), 32'd1);
        chk("abort.ready", 32'(tx_ready), 32'd1);
        chk("abort.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort.idle%0d", k), 32'(ser_out), 32'd1);
            chk($sformatf("abort.rdy%0d", k), 32'(tx_ready), 32'd1);
        end

        // Basic frame, inputs scrambled after accept
        tx_valid = 1'b1; tx_port = 2'b01; tx_len = 4'd5; tx_data = 16'h0015;
`ifdef PARITY_EN
        run_frame("f2", 32'h56A, 13, 1'b1, 2'b10, 4'd9, 16'hA5A5);
`else
        run_frame("f2", 32'h2B5, 12, 1'b1, 2'b10, 4'd9, 16'hA5A5);
`endif

        // Zero-length payload
        tx_valid = 1'b1; tx_port = 2'b11; tx_len = 4'd0; tx_data = 16'hFFFF;
`ifdef PARITY_EN
        run_frame("f3", 32'h60, 8, 1'b1, 2'b00, 4'd15, 16'h0000);
`else
        run_frame("f3", 32'h30, 7, 1'b1, 2'b00, 4'd15, 16'h0000);
`endif

        // Back-to-back with valid held: second request presented mid-frame
        tx_valid = 1'b1; tx_port = 2'b10; tx_len = 4'd3; tx_data = 16'hFFF5;
`ifdef PARITY_EN
        run_frame("f4a", 32'h23B, 11, 1'b0, 2'b00, 4'd1, 16'hFFF1);
        run_frame("f4b", 32'h06, 9, 1'b1, 2'b11, 4'd7, 16'h0000);
`else
        run_frame("f4a", 32'h11D, 10, 1'b0, 2'b00, 4'd1, 16'hFFF1);
        run_frame("f4b", 32'h03, 8, 1'b1, 2'b11, 4'd7, 16'h0000);
`endif

        // Maximum payload length
        tx_valid = 1'b1; tx_port = 2'b10; tx_len = 4'd15; tx_data = 16'hFFFF;
`ifdef PARITY_EN
        run_frame("f5", 32'h2FFFFE, 23, 1'b1, 2'b01, 4'd0, 16'h0000);
`else
        run_frame("f5", 32'h17FFFF, 22, 1'b1, 2'b01, 4'd0, 16'h0000);
`endif

`ifdef PARITY_EN
        // Even parity with an even count of ones
        tx_valid = 1'b1; tx_port = 2'b01; tx_len = 4'd2; tx_data = 16'h0003;
        run_frame("f6", 32'h096, 10, 1'b1, 2'b00, 4'd0, 16'h0000);
`endif

        repeat (3) begin
            @(negedge clk);
            chk("tail.line", 32'(ser_out), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
